cla_sub_pipe: RTL and testbench

Pipelined N-bit subtractor computing diff = a - b - bin. It is the inverse-direction companion to the team's 4-bit carry-lookahead adder. Operands are split into 4-bit borrow-lookahead slices, one pipeline stage per slice, and the borrow ripples stage to stage. It sits on the datapath between operand producers and consumers and uses a valid/ready handshake on both sides.

---
 rtl/cla_sub_pipe_pkg.sv | 24 ++
 rtl/cla_sub_pipe_4bit.sv | 30 +++
 rtl/cla_sub_pipe.sv | 88 ++++++++
 tb/tb_cla_sub_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_sub_pipe_pkg.sv
// Shared constants and the per-stage pipeline record for the borrow-lookahead subtractor.
// Stage records are sized for the widest supported operand; narrower instances zero-extend.
package cla_sub_pipe_pkg;

  localparam int SLICE_W = 4;
  localparam int MAX_W   = 64;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  // a_hi/b_hi hold the not-yet-processed operand bits, already shifted down so the
  // next slice always reads bits [SLICE_W-1:0].
  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] diff_lo;
    logic [MAX_W-1:0] a_hi;
    logic [MAX_W-1:0] b_hi;
    logic             borrow;
    logic             sa;
    logic             sb;
  } stage_t;

endpackage

// File: rtl/cla_sub_pipe_4bit.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bi, bo = borrow out.
// Every internal borrow is a flat sum of products, so nothing ripples inside the slice.
module cla_sub_4bit
  import cla_sub_pipe_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = ~(a ^ b);
  assign g = ~a & b;

  assign c[0] = bi;
  assign c[1] = g[0] | (p[0] & bi);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d  = a ^ b ^ c[SLICE_W-1:0];
  assign bo = c[SLICE_W];

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined subtractor diff = a - b - bin, one 4-bit borrow-lookahead slice per stage.
// A single global enable stalls the whole pipe when the consumer backpressures a valid result.
module cla_sub_pipe
  import cla_sub_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = nslice(WIDTH);

  logic               en;
  stage_t             head;
  stage_t             src_arr [NSLICE];
  stage_t             nxt_arr [NSLICE];
  stage_t             stg_q   [NSLICE];
  logic [SLICE_W-1:0] d_arr   [NSLICE];
  logic               bo_arr  [NSLICE];

  // Bubbles enter as all-zero records so an idle pipe drives diff/bout/ovf low.
  always_comb begin
    head = '0;
    if (in_valid) begin
      head.valid  = 1'b1;
      head.a_hi   = MAX_W'(a);
      head.b_hi   = MAX_W'(b);
      head.borrow = bin;
      head.sa     = a[WIDTH-1];
      head.sb     = b[WIDTH-1];
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_arr[k] = head;
    end else begin : g_link
      assign src_arr[k] = stg_q[k-1];
    end

    cla_sub_4bit u_slice (
      .a  (src_arr[k].a_hi[SLICE_W-1:0]),
      .b  (src_arr[k].b_hi[SLICE_W-1:0]),
      .bi (src_arr[k].borrow),
      .d  (d_arr[k]),
      .bo (bo_arr[k])
    );

    assign nxt_arr[k] = '{
      valid:   src_arr[k].valid,
      diff_lo: src_arr[k].diff_lo | (MAX_W'(d_arr[k]) << (SLICE_W * k)),
      a_hi:    src_arr[k].a_hi >> SLICE_W,
      b_hi:    src_arr[k].b_hi >> SLICE_W,
      borrow:  bo_arr[k],
      sa:      src_arr[k].sa,
      sb:      src_arr[k].sb
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSLICE; k++) stg_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NSLICE; k++) stg_q[k] <= nxt_arr[k];
    end
  end

  assign out_valid = stg_q[NSLICE-1].valid;
  assign diff      = stg_q[NSLICE-1].diff_lo[WIDTH-1:0];
  assign bout      = stg_q[NSLICE-1].borrow;
  assign ovf       = (stg_q[NSLICE-1].sa ^ stg_q[NSLICE-1].sb)
                   & (diff[WIDTH-1] ^ stg_q[NSLICE-1].sa);

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe (WIDTH=16): directed boundaries, backpressure,
// mid-flight reset and a randomized regression against an integer-arithmetic reference.
module tb_cla_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  cla_sub_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t r;
    int   du;
    int   ds;
    du   = int'(x) - int'(y) - int'(c);
    ds   = int'($signed(x)) - int'($signed(y)) - int'(c);
    r.d  = du[15:0];
    r.bo = (du < 0);
    r.ov = (ds > 32767) || (ds < -32768);
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, sample just after, transfer at the next rise.
  task automatic drive_cycle(input logic r, input logic v, input logic [15:0] ia,
                             input logic [15:0] ib, input logic ic, input logic ordy,
                             output logic ifire, output logic ofire, output logic [15:0] od,
                             output logic ob, output logic oo, output logic irdy,
                             output logic ov);
    @(negedge clk);
    rst = r; in_valid = v; a = ia; b = ib; bin = ic; out_ready = ordy;
    #1;
    irdy  = in_ready;
    ov    = out_valid;
    od    = diff;
    ob    = bout;
    oo    = ovf;
    ifire = v && in_ready && !r;
    ofire = out_valid && ordy && !r;
  endtask

  // Sends one operand triple into an empty pipe and waits (bounded) for its result.
  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         output logic [15:0] od, output logic ob, output logic oo,
                         output int lat);
    logic ifire, ofire, irdy, ov;
    lat = -1;
    drive_cycle(1'b0, 1'b1, ia, ib, ic, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
    for (int i = 1; i < 20; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
      if (ov) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic ifire, ofire, ob, oo, irdy, ov;
    logic [15:0] od;
    drive_cycle(1'b1, 1'b1, 16'h1234, 16'h0001, 1'b1, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
    drive_cycle(1'b1, 1'b1, 16'h5555, 16'h0003, 1'b0, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
    tests++;
    if (ov !== 1'b0 || od !== 16'h0 || ob !== 1'b0 || oo !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b diff=%h bout=%b ovf=%b, want 0 0000 0 0",
               ov, od, ob, oo);
    end
    tests++;
    if (irdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", irdy);
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
      tests++;
      if (ov !== 1'b0 || od !== 16'h0) begin
        fails++;
        $display("FAIL reset_no_capture: cycle %0d got valid=%b diff=%h want 0 0000", i, ov, od);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] od;
    logic ob, oo;
    int lat;
    run_one(16'h0005, 16'h0003, 1'b0, od, ob, oo, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    tests++;
    if (od !== 16'h0002 || ob !== 1'b0 || oo !== 1'b0) begin
      fails++;
      $display("FAIL basic_value: got diff=%h bout=%b ovf=%b want 0002 0 0", od, ob, oo);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] va [5] = '{16'h1000, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] wd [5] = '{16'h0FFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic        wb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        wo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] od;
    logic ob, oo;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_one(va[i], vb[i], vc[i], od, ob, oo, lat);
      tests++;
      if (lat !== 4 || od !== wd[i] || ob !== wb[i] || oo !== wo[i]) begin
        fails++;
        $display("FAIL boundary_%0d: got lat=%0d diff=%h bout=%b ovf=%b want lat=4 diff=%h bout=%b ovf=%b",
                 i, lat, od, ob, oo, wd[i], wb[i], wo[i]);
      end
    end
    run_one(16'hABCD, 16'hABCD, 1'b0, od, ob, oo, lat);
    tests++;
    if (od !== 16'h0000 || ob !== 1'b0 || oo !== 1'b0) begin
      fails++;
      $display("FAIL equal_no_borrow: got diff=%h bout=%b ovf=%b want 0000 0 0", od, ob, oo);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [8];
    logic [15:0] pb [8];
    logic        pc [8];
    logic ifire, ofire, ob, oo, irdy, ov, ordy, prev_stall;
    logic [15:0] od, prev_d;
    exp_t e;
    int sent, got, cyc, last_out, k;
    for (int i = 0; i < 8; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
      pc[i] = 1'($urandom);
    end
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; last_out = -1; prev_stall = 1'b0; prev_d = '0;
    while (got < 8 && cyc < 60) begin
      ordy = !(cyc >= 6 && cyc <= 8);
      k = (sent < 8) ? sent : 0;
      drive_cycle(1'b0, sent < 8, pa[k], pb[k], pc[k], ordy, ifire, ofire, od, ob, oo, irdy, ov);
      tests++;
      if (irdy !== !(ov && !ordy)) begin
        fails++;
        $display("FAIL b2b_in_ready: cycle %0d got %b want %b", cyc, irdy, !(ov && !ordy));
      end
      if (prev_stall) begin
        tests++;
        if (ov !== 1'b1 || od !== prev_d) begin
          fails++;
          $display("FAIL b2b_hold: cycle %0d got valid=%b diff=%h want 1 %h", cyc, ov, od, prev_d);
        end
      end
      if (ifire) begin
        exp_q.push_back(model(pa[k], pb[k], pc[k]));
        sent++;
      end
      if (ofire) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected: cycle %0d got diff=%h want no output", cyc, od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.d || ob !== e.bo || oo !== e.ov) begin
            fails++;
            $display("FAIL b2b_result_%0d: got diff=%h bout=%b ovf=%b want %h %b %b",
                     got, od, ob, oo, e.d, e.bo, e.ov);
          end
        end
        if (cyc >= 10) begin
          tests++;
          if (last_out !== cyc - 1) begin
            fails++;
            $display("FAIL b2b_throughput: cycle %0d previous output at %0d want %0d",
                     cyc, last_out, cyc - 1);
          end
        end
        last_out = cyc;
        got++;
      end
      prev_stall = ov && !ordy;
      prev_d = od;
      cyc++;
    end
    tests++;
    if (got !== 8 || last_out !== 14) begin
      fails++;
      $display("FAIL b2b_completion: got %0d results last at cycle %0d want 8 results last at 14",
               got, last_out);
    end
  endtask

  task automatic test_reset_midflight();
    logic ifire, ofire, ob, oo, irdy, ov;
    logic [15:0] od;
    int lat;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1,
                  ifire, ofire, od, ob, oo, irdy, ov);
    drive_cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ifire, ofire, od, ob, oo, irdy, ov);
      tests++;
      if (ov !== 1'b0 || od !== 16'h0 || ob !== 1'b0 || oo !== 1'b0 || irdy !== 1'b1) begin
        fails++;
        $display("FAIL midreset_flush: cycle %0d got valid=%b diff=%h bout=%b ovf=%b rdy=%b want 0 0000 0 0 1",
                 i, ov, od, ob, oo, irdy);
      end
    end
    run_one(16'h00F0, 16'h000F, 1'b1, od, ob, oo, lat);
    tests++;
    if (lat !== 4 || od !== 16'h00E0 || ob !== 1'b0 || oo !== 1'b0) begin
      fails++;
      $display("FAIL midreset_recover: got lat=%0d diff=%h bout=%b ovf=%b want 4 00E0 0 0",
               lat, od, ob, oo);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic ifire, ofire, ob, oo, irdy, ov, ordy, cv, cc;
    logic [15:0] od, ca, cb;
    exp_t e;
    int sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    cv = 1'($urandom_range(0, 4) != 0);
    ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
    while ((sent < N || got < sent) && cyc < 60000) begin
      ordy = ($urandom_range(0, 9) < 7);
      drive_cycle(1'b0, cv && (sent < N), ca, cb, cc, ordy, ifire, ofire, od, ob, oo, irdy, ov);
      if (irdy !== !(ov && !ordy)) begin
        tests++;
        fails++;
        $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, irdy, !(ov && !ordy));
      end
      if (ifire) begin
        exp_q.push_back(model(ca, cb, cc));
        sent++;
      end
      if (ofire) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rand_unexpected: cycle %0d got diff=%h want no output", cyc, od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.d || ob !== e.bo || oo !== e.ov) begin
            fails++;
            $display("FAIL rand_result_%0d: got diff=%h bout=%b ovf=%b want %h %b %b",
                     got, od, ob, oo, e.d, e.bo, e.ov);
          end
        end
        got++;
      end
      if (ifire || !cv) begin
        cv = 1'($urandom_range(0, 4) != 0);
        ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
      end
      cyc++;
    end
    tests++;
    if (sent !== N || got !== sent) begin
      fails++;
      $display("FAIL rand_counts: sent %0d received %0d want %0d each", sent, got, N);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
